// File: rtl/sq_arb_pkg.sv
// Shared types and defaults for the sq_pipe_arbiter slice: FSM state
// encoding, default datapath widths and a constant clog2 helper.
package sq_arb_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_e;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_IN_W     = 4;
    localparam int DEF_OUT_W    = 32;
    localparam int DEF_PIPE_LAT = 3;

    // Smallest r with 2**r >= value; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sq_arb_grant.sv
// Grant selection for sq_pipe_arbiter. One-hot grant, only to a valid
// requester, only while enabled. Build macro SQ_ARB_RR_EN selects
// round-robin (with its pointer register); otherwise fixed priority,
// lowest index first, with no state.
module sq_arb_grant
    import sq_arb_pkg::*;
#(
    parameter int  N_REQ = DEF_N_REQ,
    localparam int ID_W  = clog2(N_REQ)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] i_valid,
    input  logic             i_enable,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_grant_id
);

`ifdef SQ_ARB_RR_EN
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W:0]   idx;
    logic            found;

    // Scan from the pointer with wrap; the pointer moves past the winner only when a grant is issued.
    always_comb begin
        o_grant    = '0;
        o_grant_id = '0;
        found      = 1'b0;
        idx        = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(N_REQ)) idx = idx - (ID_W+1)'(N_REQ);
            if (!found && i_enable && i_valid[idx[ID_W-1:0]]) begin
                found                   = 1'b1;
                o_grant[idx[ID_W-1:0]]  = 1'b1;
                o_grant_id              = idx[ID_W-1:0];
            end
        end
        ptr_d = ptr_q;
        if (found) ptr_d = (o_grant_id == ID_W'(N_REQ - 1)) ? '0 : o_grant_id + ID_W'(1);
    end

    // Round-robin pointer register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`else
    logic found;
    logic unused_clk_rst;
    assign unused_clk_rst = clock ^ reset;

    // Fixed priority: the lowest-index valid requester wins.
    always_comb begin
        o_grant    = '0;
        o_grant_id = '0;
        found      = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && i_enable && i_valid[i]) begin
                found      = 1'b1;
                o_grant[i] = 1'b1;
                o_grant_id = ID_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/sq_pipe_arbiter.sv
// Arbiter sharing one fixed-latency fourth-power pipeline among N_REQ
// requesters. Issues one tagged operand per cycle, returns results on a
// tagged response bus, flags tag/valid mismatches, and offers a
// flush/drain handshake. Build macro SQ_ARB_RR_EN selects round-robin
// arbitration inside sq_arb_grant (fixed priority when undefined).
module sq_pipe_arbiter
    import sq_arb_pkg::*;
#(
    parameter int  N_REQ    = DEF_N_REQ,
    parameter int  IN_W     = DEF_IN_W,
    parameter int  OUT_W    = DEF_OUT_W,
    parameter int  PIPE_LAT = DEF_PIPE_LAT,
    localparam int ID_W     = clog2(N_REQ)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      i_req_valid,
    input  logic [N_REQ*IN_W-1:0] i_req_value,
    output logic [N_REQ-1:0]      o_req_ready,
    output logic [IN_W-1:0]       o_pipe_value,
    output logic                  o_pipe_valid,
    input  logic [OUT_W-1:0]      i_pipe_value,
    input  logic                  i_pipe_valid,
    output logic                  o_rsp_valid,
    output logic [ID_W-1:0]       o_rsp_id,
    output logic [OUT_W-1:0]      o_rsp_value,
    input  logic                  i_flush,
    output logic                  o_flush_done,
    output logic                  o_err
);

    localparam int CNT_W = clog2(PIPE_LAT + 2);

    arb_state_e       state_q;
    logic             flush_done_q;
    logic             grant_en;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_id;
    logic             accept;
    logic [IN_W-1:0]  operand;

    // Issue register: operand plus the tag that rides with it.
    logic             pipe_valid_q, pipe_valid_d;
    logic [IN_W-1:0]  pipe_value_q, pipe_value_d;
    logic [ID_W-1:0]  issue_id_q, issue_id_d;

    // Tag delay line matching the pipeline latency behind the issue register.
    logic [PIPE_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [ID_W-1:0]     tag_id_q [PIPE_LAT];
    logic [ID_W-1:0]     tag_id_d [PIPE_LAT];
    logic                tail_vld;
    logic [ID_W-1:0]     tail_id;

    logic             rsp_fire;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic [OUT_W-1:0] rsp_value_q, rsp_value_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // No grants while in reset, outside RUN, or while a flush is requested.
    assign grant_en = reset && (state_q == ST_RUN) && !i_flush;

    sq_arb_grant #(.N_REQ(N_REQ)) u_grant (
        .clock      (clock),
        .reset      (reset),
        .i_valid    (i_req_valid),
        .i_enable   (grant_en),
        .o_grant    (grant),
        .o_grant_id (grant_id)
    );

    assign accept   = |grant;
    assign operand  = i_req_value[grant_id*IN_W +: IN_W];
    assign tail_vld = tag_vld_q[PIPE_LAT-1];
    assign tail_id  = tag_id_q[PIPE_LAT-1];
    assign rsp_fire = i_pipe_valid && tail_vld;

    // Next-state for issue, tag line, response, error flag and in-flight count.
    always_comb begin
        pipe_valid_d = accept;
        pipe_value_d = pipe_value_q;
        issue_id_d   = issue_id_q;
        if (accept) begin
            pipe_value_d = operand;
            issue_id_d   = grant_id;
        end

        tag_vld_d[0] = pipe_valid_q;
        tag_id_d[0]  = issue_id_q;
        for (int k = 1; k < PIPE_LAT; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_id_d[k]  = tag_id_q[k-1];
        end

        rsp_valid_d = rsp_fire;
        rsp_id_d    = rsp_fire ? tail_id      : rsp_id_q;
        rsp_value_d = rsp_fire ? i_pipe_value : rsp_value_q;

        err_d = err_q || (i_pipe_valid != tail_vld);

        // Count tags rather than results so a dropped result cannot wedge a drain.
        cnt_d = cnt_q;
        case ({accept, tail_vld})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Datapath and status registers; reset also discards every in-flight tag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pipe_valid_q <= 1'b0;
            pipe_value_q <= '0;
            issue_id_q   <= '0;
            tag_vld_q    <= '0;
            for (int k = 0; k < PIPE_LAT; k++) tag_id_q[k] <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_value_q  <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            pipe_valid_q <= pipe_valid_d;
            pipe_value_q <= pipe_value_d;
            issue_id_q   <= issue_id_d;
            tag_vld_q    <= tag_vld_d;
            for (int k = 0; k < PIPE_LAT; k++) tag_id_q[k] <= tag_id_d[k];
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_value_q  <= rsp_value_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    // Flush FSM with registered done flag; dropping i_flush always returns to RUN.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (i_flush) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!i_flush) begin
                        state_q <= ST_RUN;
                    end else if (cnt_q == '0) begin
                        state_q      <= ST_DONE;
                        flush_done_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!i_flush) state_q <= ST_RUN;
                    else          flush_done_q <= 1'b1;
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign o_req_ready  = grant;
    assign o_pipe_valid = pipe_valid_q;
    assign o_pipe_value = pipe_value_q;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_id     = rsp_id_q;
    assign o_rsp_value  = rsp_value_q;
    assign o_flush_done = flush_done_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_sq_pipe_arbiter.sv
// Self-checking bench for sq_pipe_arbiter (N_REQ=4, IN_W=4, OUT_W=32,
// PIPE_LAT=3). Includes a behavioural fourth-power pipeline; expected
// arbitration follows SQ_ARB_RR_EN when it is defined for the build.
module tb_sq_pipe_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  i_req_valid;
    logic [15:0] i_req_value;
    wire  [3:0]  o_req_ready;
    wire  [3:0]  o_pipe_value;
    wire         o_pipe_valid;
    wire  [31:0] i_pipe_value;
    wire         i_pipe_valid;
    wire         o_rsp_valid;
    wire  [1:0]  o_rsp_id;
    wire  [31:0] o_rsp_value;
    logic        i_flush;
    wire         o_flush_done;
    wire         o_err;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    sq_pipe_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .i_req_valid  (i_req_valid),
        .i_req_value  (i_req_value),
        .o_req_ready  (o_req_ready),
        .o_pipe_value (o_pipe_value),
        .o_pipe_valid (o_pipe_valid),
        .i_pipe_value (i_pipe_value),
        .i_pipe_valid (i_pipe_valid),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_id     (o_rsp_id),
        .o_rsp_value  (o_rsp_value),
        .i_flush      (i_flush),
        .o_flush_done (o_flush_done),
        .o_err        (o_err)
    );

    function automatic logic [31:0] pow4(input logic [3:0] v);
        int x;
        x = int'(v);
        return 32'(x * x * x * x);
    endfunction

    // Behavioural shared pipeline: three cycles, no reset, plus a spurious-valid injector.
    bit [2:0]  pv_sh;
    bit [31:0] pd_sh [3];
    bit        inj;
    always @(posedge clock) begin
        pv_sh    <= {pv_sh[1:0], o_pipe_valid};
        pd_sh[0] <= pow4(o_pipe_value);
        pd_sh[1] <= pd_sh[0];
        pd_sh[2] <= pd_sh[1];
    end
    assign i_pipe_valid = pv_sh[2] | inj;
    assign i_pipe_value = pd_sh[2];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // First valid requester at or after ptr, wrapping; -1 when none.
    function automatic int pick(input logic [3:0] v, input int ptr);
        for (int i = 0; i < 4; i++) begin
            int k;
            k = (ptr + i) % 4;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    typedef struct {
        logic [3:0]  mask;
        logic [15:0] vals;
        logic [3:0]  ready;
        logic [3:0]  op;
        logic [1:0]  id;
        logic [31:0] res;
    } vec_t;
    vec_t vecs [6];

    typedef struct {
        int          id;
        logic [31:0] val;
        int          due;
    } rsp_t;
    rsp_t q [$];

    localparam int M_RUN = 0, M_DRAIN = 1, M_DONE = 2;

    initial begin
        int seen;
        bit done;
        int mstate, nstate, ptr, g, cyc, qs;
        bit exp_rv, exp_pv, exp_done;
        int exp_id;
        logic [31:0] exp_val;
        logic [3:0]  exp_pval, opv;

        vecs[0] = '{4'b0010, 16'h5F3E, 4'b0010, 4'd3,  2'd1, 32'd81};
        vecs[1] = '{4'b0001, 16'h777F, 4'b0001, 4'd15, 2'd0, 32'd50625};
        vecs[2] = '{4'b1000, 16'h2ABC, 4'b1000, 4'd2,  2'd3, 32'd16};
        vecs[3] = '{4'b0100, 16'h1023, 4'b0100, 4'd0,  2'd2, 32'd0};
        vecs[4] = '{4'b0010, 16'hFFAF, 4'b0010, 4'd10, 2'd1, 32'd10000};
        vecs[5] = '{4'b1000, 16'hC123, 4'b1000, 4'd12, 2'd3, 32'd20736};

        inj = 1'b0;
        reset = 1'b0;
        i_flush = 1'b0;
        i_req_valid = 4'b0000;
        i_req_value = 16'h0000;

        // Reset state, with requests pending to prove grants are held off.
        tick();
        tick();
        i_req_valid = 4'b1111;
        i_req_value = 16'h4321;
        #2;
        check("rst_ready", o_req_ready, 0);
        check("rst_pipe_valid", o_pipe_valid, 0);
        check("rst_pipe_value", o_pipe_value, 0);
        check("rst_rsp_valid", o_rsp_valid, 0);
        check("rst_rsp_id", o_rsp_id, 0);
        check("rst_rsp_value", o_rsp_value, 0);
        check("rst_flush_done", o_flush_done, 0);
        check("rst_err", o_err, 0);
        i_req_valid = 4'b0000;
        reset = 1'b1;
        tick();

        // Table: single accepted request and its tagged response four cycles later.
        for (int v = 0; v < 6; v++) begin
            i_req_valid = vecs[v].mask;
            i_req_value = vecs[v].vals;
            #2;
            check("vec_ready", o_req_ready, vecs[v].ready);
            tick();
            i_req_valid = 4'b0000;
            #1;
            check("vec_pipe_valid", o_pipe_valid, 1);
            check("vec_pipe_value", o_pipe_value, vecs[v].op);
            tick();
            tick();
            tick();
            check("vec_rsp_early", o_rsp_valid, 0);
            tick();
            check("vec_rsp_valid", o_rsp_valid, 1);
            check("vec_rsp_id", o_rsp_id, vecs[v].id);
            check("vec_rsp_value", o_rsp_value, vecs[v].res);
            tick();
            check("vec_rsp_pulse", o_rsp_valid, 0);
            check("vec_pipe_hold", o_pipe_value, vecs[v].op);
        end

        // All four requesters held valid: grant order and back-to-back responses.
        do_reset();
        i_req_valid = 4'b1111;
        i_req_value = 16'h4321;
        for (int c = 0; c < 4; c++) begin
            #2;
`ifdef SQ_ARB_RR_EN
            check("all4_grant", o_req_ready, 32'(1 << c));
`else
            check("all4_grant", o_req_ready, 4'b0001);
`endif
            tick();
        end
        i_req_valid = 4'b0000;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("all4_rsp_valid", o_rsp_valid, 1);
`ifdef SQ_ARB_RR_EN
            check("all4_rsp_id", o_rsp_id, c);
            check("all4_rsp_value", o_rsp_value, pow4(4'(c + 1)));
`else
            check("all4_rsp_id", o_rsp_id, 0);
            check("all4_rsp_value", o_rsp_value, 1);
`endif
        end
        tick();
        check("all4_rsp_end", o_rsp_valid, 0);

        // Flush with three results in flight.
        i_req_valid = 4'b0001;
        i_req_value = 16'h0005;
        for (int c = 0; c < 3; c++) begin
            #2;
            check("flush_pre_grant", o_req_ready, 4'b0001);
            tick();
        end
        i_flush = 1'b1;
        seen = 0;
        done = 1'b0;
        for (int c = 0; c < 12 && !done; c++) begin
            #2;
            check("flush_no_grant", o_req_ready, 0);
            if (o_rsp_valid) seen++;
            if (o_flush_done) done = 1'b1;
            else tick();
        end
        check("flush_done_seen", 32'(done), 1);
        check("flush_rsp_before_done", seen, 3);
        i_flush = 1'b0;
        #1;
        check("flush_done_no_grant", o_req_ready, 0);
        tick();
        #2;
        check("flush_resume_grant", o_req_ready, 4'b0001);
        check("flush_done_clear", o_flush_done, 0);
        i_req_valid = 4'b0000;
        repeat (6) tick();

        // Spurious pipeline valid with no tag: sticky error, no response.
        inj = 1'b1;
        tick();
        inj = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("err_set", o_err, 1);
            check("err_no_rsp", o_rsp_valid, 0);
            tick();
        end
        reset = 1'b0;
        #1;
        check("err_cleared_by_reset", o_err, 0);
        tick();
        reset = 1'b1;
        tick();

        // Reset two cycles after an accept: late result is untagged.
        i_req_valid = 4'b0100;
        i_req_value = 16'h0700;
        tick();
        i_req_valid = 4'b0000;
        tick();
        tick();
        reset = 1'b0;
        #2;
        check("midrst_pipe_value", o_pipe_value, 0);
        check("midrst_pipe_valid", o_pipe_valid, 0);
        check("midrst_rsp_valid", o_rsp_valid, 0);
        check("midrst_err", o_err, 0);
        #3;
        reset = 1'b1;
        tick();
        tick();
        check("midrst_late_err", o_err, 1);
        check("midrst_late_no_rsp", o_rsp_valid, 0);
        tick();
        check("midrst_late_no_rsp2", o_rsp_valid, 0);

        // Randomized traffic and flushes against the reference model.
        do_reset();
        mstate = M_RUN;
        ptr = 0;
        cyc = 0;
        exp_rv = 1'b0;
        exp_pv = 1'b0;
        exp_done = 1'b0;
        exp_id = 0;
        exp_val = 0;
        exp_pval = 0;
        q.delete();
        for (int n = 0; n < 600; n++) begin
            i_req_valid = 4'($urandom);
            i_req_value = 16'($urandom);
            if (!i_flush && $urandom_range(0, 19) == 0) i_flush = 1'b1;
            else if (i_flush && $urandom_range(0, 5) == 0) i_flush = 1'b0;
            #2;
            g = (mstate == M_RUN && !i_flush) ? pick(i_req_valid, ptr) : -1;
            check("rnd_ready", o_req_ready, (g >= 0) ? 32'(1 << g) : 32'd0);
            check("rnd_rsp_valid", o_rsp_valid, 32'(exp_rv));
            if (exp_rv) begin
                check("rnd_rsp_id", o_rsp_id, exp_id);
                check("rnd_rsp_value", o_rsp_value, exp_val);
            end
            check("rnd_pipe_valid", o_pipe_valid, 32'(exp_pv));
            check("rnd_pipe_value", o_pipe_value, exp_pval);
            check("rnd_flush_done", o_flush_done, 32'(exp_done));
            check("rnd_err", o_err, 0);

            qs = q.size();
            nstate = mstate;
            case (mstate)
                M_RUN:   if (i_flush) nstate = M_DRAIN;
                M_DRAIN: if (!i_flush) nstate = M_RUN; else if (qs == 0) nstate = M_DONE;
                default: if (!i_flush) nstate = M_RUN;
            endcase
            exp_pv = (g >= 0);
            if (g >= 0) begin
                opv = i_req_value[g*4 +: 4];
                exp_pval = opv;
                q.push_back('{g, pow4(opv), cyc + 4});
`ifdef SQ_ARB_RR_EN
                ptr = (g + 1) % 4;
`endif
            end
            exp_rv = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_rv = 1'b1;
                exp_id = q[0].id;
                exp_val = q[0].val;
                void'(q.pop_front());
            end
            mstate = nstate;
            exp_done = (mstate == M_DONE);
            cyc++;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
